// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Op codes, FSM states and helpers for usr_burst_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    SHR   = 3'd1,
    SHL   = 3'd2,
    LOAD  = 3'd3,
    ROR   = 3'd4,
    ROL   = 3'd5,
    ASR   = 3'd6,
    CLEAR = 3'd7
  } usr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } usr_state_e;

  function automatic logic is_shift_op(input usr_op_e op);
    return (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL) || (op == ASR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_burst_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : usr_burst_shifter_if
// Description : Command handshake, serial and status bundle of the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface usr_burst_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data, ser_in_l, ser_in_r,
    input  cmd_ready, q, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data, ser_in_l, ser_in_r,
    output cmd_ready, q, ser_out_l, ser_out_r, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/usr_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : usr_shift_step
// Description : Combinational single-bit step of the selected shift/rotate op.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_op_e          op,
  input  logic [WIDTH-1:0] q,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      SHR:     q_next = {ser_in_r, q[WIDTH-1:1]};
      SHL:     q_next = {q[WIDTH-2:0], ser_in_l};
      ROR:     q_next = {q[0], q[WIDTH-1:1]};
      ROL:     q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      ASR:     q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/usr_burst_shifter.sv
`default_nettype none
// ============================================================================
// Module      : usr_burst_shifter
// Description : Universal shift register executing multi-bit commands one bit
//               per cycle behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_burst_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  usr_burst_shifter_if.slave   bus
);

  localparam logic [CNT_W-1:0] C_MAX_STEPS = CNT_W'(WIDTH);

  usr_state_e       r_state, w_state_next;
  usr_op_e          r_op, w_op_next;
  logic [CNT_W-1:0] r_rem, w_rem_next;
  logic [WIDTH-1:0] r_q, w_q_next;

  logic             w_accept;
  usr_op_e          w_cmd_op;
  logic [CNT_W-1:0] w_eff_count;
  logic [WIDTH-1:0] w_step_q;

  assign w_accept    = bus.cmd_valid && (r_state == IDLE);
  assign w_cmd_op    = usr_op_e'(bus.cmd_op);
  assign w_eff_count = (bus.cmd_count > C_MAX_STEPS) ? C_MAX_STEPS : bus.cmd_count;

  usr_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op       (r_op),
    .q        (r_q),
    .ser_in_l (bus.ser_in_l),
    .ser_in_r (bus.ser_in_r),
    .q_next   (w_step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= NOP;
      r_rem   <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_rem   <= w_rem_next;
      r_q     <= w_q_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_rem_next   = r_rem;
    w_q_next     = r_q;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = DONE;
          if (w_cmd_op == LOAD) begin
            w_q_next = bus.cmd_data;
          end else if (w_cmd_op == CLEAR) begin
            w_q_next = '0;
          end else if (is_shift_op(w_cmd_op) && (bus.cmd_count != '0)) begin
            w_state_next = SHIFT;
            w_op_next    = w_cmd_op;
            w_rem_next   = w_eff_count;
          end
        end
      end
      SHIFT: begin
        // Serial inputs feed the step live, so each edge sees current fill bits
        w_q_next   = w_step_q;
        w_rem_next = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state == SHIFT) || (r_state == DONE);
  assign bus.done      = (r_state == DONE);
  assign bus.q         = r_q;
  assign bus.ser_out_l = r_q[WIDTH-1];
  assign bus.ser_out_r = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_usr_burst_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_burst_shifter
// Description : Directed self-checking bench for usr_burst_shifter (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_burst_shifter;
  import usr_pkg::*;

  localparam int C_WIDTH = 8;
  localparam int C_CNT_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  usr_burst_shifter_if #(.WIDTH(C_WIDTH), .CNT_W(C_CNT_W)) bus ();

  usr_burst_shifter #(
    .WIDTH (C_WIDTH),
    .CNT_W (C_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Presents one command for a single edge; returns just after the accept edge
  task automatic send(input usr_op_e op, input logic [3:0] count, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = count;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] data);
    send(LOAD, 4'd0, data);
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    bus.ser_in_l  = 1'b0;
    bus.ser_in_r  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_q",     32'(bus.q),         32'h00);
    check("rst_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_busy",  32'(bus.busy),      32'h0);
    check("rst_done",  32'(bus.done),      32'h0);

    // LOAD 0xA5 with a second LOAD held through DONE
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = LOAD;
    bus.cmd_count = 4'd0;
    bus.cmd_data  = 8'hA5;
    tick();
    check("load_q",     32'(bus.q),         32'hA5);
    check("load_done",  32'(bus.done),      32'h1);
    check("load_ready", 32'(bus.cmd_ready), 32'h0);
    check("load_busy",  32'(bus.busy),      32'h1);
    bus.cmd_data = 8'h5A;
    tick();
    check("hold_q_not_taken", 32'(bus.q),         32'hA5);
    check("hold_done_low",    32'(bus.done),      32'h0);
    check("hold_ready_back",  32'(bus.cmd_ready), 32'h1);
    tick();
    bus.cmd_valid = 1'b0;
    check("second_load_q",    32'(bus.q),    32'h5A);
    check("second_load_done", 32'(bus.done), 32'h1);
    tick();

    // ROL x3 from 0xA5
    load(8'hA5);
    send(ROL, 4'd3, 8'h00);
    check("rol_e_q",    32'(bus.q),    32'hA5);
    check("rol_e_busy", 32'(bus.busy), 32'h1);
    check("rol_e_done", 32'(bus.done), 32'h0);
    tick();
    check("rol_s1", 32'(bus.q), 32'h4B);
    tick();
    check("rol_s2",      32'(bus.q),    32'h96);
    check("rol_s2_done", 32'(bus.done), 32'h0);
    tick();
    check("rol_s3",      32'(bus.q),    32'h2D);
    check("rol_s3_done", 32'(bus.done), 32'h1);
    tick();
    check("rol_after_done",  32'(bus.done),      32'h0);
    check("rol_after_ready", 32'(bus.cmd_ready), 32'h1);

    // ASR x2 from 0x90
    load(8'h90);
    send(ASR, 4'd2, 8'h00);
    tick();
    check("asr_s1", 32'(bus.q), 32'hC8);
    tick();
    check("asr_s2",      32'(bus.q),         32'hE4);
    check("asr_done",    32'(bus.done),      32'h1);
    check("asr_ser_l",   32'(bus.ser_out_l), 32'h1);
    check("asr_ser_r",   32'(bus.ser_out_r), 32'h0);
    tick();

    // SHR x1 from 0x01 with MSB fill of 1
    load(8'h01);
    check("shr_pre_ser_r", 32'(bus.ser_out_r), 32'h1);
    bus.ser_in_r = 1'b1;
    send(SHR, 4'd1, 8'h00);
    tick();
    check("shr_q",    32'(bus.q),    32'h80);
    check("shr_done", 32'(bus.done), 32'h1);
    tick();
    bus.ser_in_r = 1'b0;

    // Shift with zero count behaves like LOAD timing, q unchanged
    send(SHL, 4'd0, 8'h00);
    check("shl0_q",    32'(bus.q),    32'h80);
    check("shl0_done", 32'(bus.done), 32'h1);
    tick();

    // SHL x10 saturates to 8 steps of ones
    send(CLEAR, 4'd0, 8'h00);
    check("clear_q", 32'(bus.q), 32'h00);
    tick();
    bus.ser_in_l = 1'b1;
    send(SHL, 4'd10, 8'h00);
    for (int i = 0; i < 7; i++) tick();
    check("shl_e7_q",    32'(bus.q),    32'h7F);
    check("shl_e7_done", 32'(bus.done), 32'h0);
    tick();
    check("shl_e8_q",    32'(bus.q),    32'hFF);
    check("shl_e8_done", 32'(bus.done), 32'h1);
    tick();
    check("shl_e9_done",  32'(bus.done),      32'h0);
    check("shl_e9_ready", 32'(bus.cmd_ready), 32'h1);
    bus.ser_in_l = 1'b0;

    // ROR x15 saturates to a full rotation
    load(8'h3C);
    send(ROR, 4'd15, 8'h00);
    for (int i = 0; i < 7; i++) tick();
    check("ror_e7_q",    32'(bus.q),    32'h78);
    check("ror_e7_busy", 32'(bus.busy), 32'h1);
    tick();
    check("ror_e8_q",    32'(bus.q),    32'h3C);
    check("ror_e8_done", 32'(bus.done), 32'h1);
    tick();

    // Reset during SHR x5 from 0xFF aborts without done
    load(8'hFF);
    send(SHR, 4'd5, 8'h00);
    tick();
    check("abort_s1", 32'(bus.q), 32'h7F);
    tick();
    check("abort_s2", 32'(bus.q), 32'h3F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_q",     32'(bus.q),         32'h00);
    check("abort_ready", 32'(bus.cmd_ready), 32'h1);
    check("abort_busy",  32'(bus.busy),      32'h0);
    check("abort_done",  32'(bus.done),      32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done", 32'(bus.done), 32'h0);
    end
    check("abort_q_stays", 32'(bus.q), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usr_burst_shifter.md
# usr_burst_shifter

Parametrised universal shift register with a command interface. It extends the fixed 4-bit hold/shift/load register family with several additions: configurable width, serial fill inputs, rotate and arithmetic modes, multi-bit shift counts executed one bit per cycle, and a valid/ready command handshake with a completion pulse. It sits between a control sequencer, which issues commands, and datapath logic, which consumes `q` and the serial outputs.

## Interface
Parameters:
- `WIDTH`, 8: register width in bits; must be ≥ 2.
- `CNT_W`, 4: width of `cmd_count`; must be large enough to hold `WIDTH`.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command; high only in IDLE.
- `cmd_op`  in  3: operation code (see Operation).
- `cmd_count`  in  CNT_W: number of single-bit shift steps.
- `cmd_data`  in  WIDTH: parallel load value.
- `ser_in_l`  in  1: bit entering the LSB on SHL.
- `ser_in_r`  in  1: bit entering the MSB on SHR.
- `q`  out  WIDTH: register contents.
- `ser_out_l`  out  1: `q[WIDTH-1]`, combinational from `q`.
- `ser_out_r`  out  1: `q[0]`, combinational from `q`.
- `busy`  out  1: high in SHIFT or DONE.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation
Op codes:
- 0 NOP: no change.
- 1 SHR: logical right shift, `ser_in_r` fills the MSB.
- 2 SHL: left shift, `ser_in_l` fills the LSB.
- 3 LOAD: `q` ← `cmd_data`.
- 4 ROR: rotate right.
- 5 ROL: rotate left.
- 6 ASR: arithmetic right shift; the MSB is replicated.
- 7 CLEAR: `q` ← 0.

Command acceptance:
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- `cmd_op`, `cmd_count` and `cmd_data` are sampled only at the accept edge.
- `cmd_valid` while not ready is ignored. The source must hold the command until it is accepted.

FSM states:
- IDLE: `cmd_ready`=1. On accept:
  - LOAD, CLEAR or NOP: update `q` at the accept edge, then go to DONE.
  - Shift op (1,2,4,5,6) with count 0: `q` unchanged, go to DONE.
  - Shift op with count ≥ 1: load `remaining` ← min(`cmd_count`, `WIDTH`), latch the op, go to SHIFT.
- SHIFT: on each edge, apply one single-bit step of the latched op and decrement `remaining`.
  - When the step is taken with `remaining`==1, go to DONE.
  - Serial inputs are sampled live at every step edge, not latched at accept.
- DONE: `done`=1 and `cmd_ready`=0 for exactly one cycle, then IDLE.

Count rule: counts above `WIDTH` saturate to `WIDTH`. A saturated rotate therefore returns the original value; saturated SHL/SHR yield `WIDTH` serial-fill bits.

Reset (any state, including mid-SHIFT):
- Next edge: `q`=0, state IDLE, `remaining`=0.
- Outputs: `cmd_ready`=1, `busy`=0, `done`=0.
- No `done` is issued for an aborted command.

## Timing
- Accept edge is E.
- LOAD/CLEAR/NOP: `q` valid after E; `done` high during cycle E→E+1; `cmd_ready` high after E+1. Throughput is 2 cycles per command.
- Shift with effective count N ≥ 1:
  - Steps occur at edges E+1 … E+N.
  - Final `q` is visible after E+N.
  - `done` is high during cycle E+N→E+N+1.
  - Next accept is possible at E+N+2.
- Shift with count 0: same timing as LOAD.
- `done` and `busy` are registered outputs. `ser_out_*` follow `q` with zero latency.

## Structure
- Package `usr_pkg`:
  - `usr_op_e` enum with the 3-bit op codes.
  - `usr_state_e` enum {IDLE, SHIFT, DONE}.
- Sub-module `usr_shift_step`: purely combinational, performs one single-bit step given `op`, `q`, `ser_in_l` and `ser_in_r`, and is parametrised on `WIDTH`.
- The top level holds the FSM, `remaining` counter, latched op and `q` register.

## Test plan
All scenarios use `WIDTH`=8.
- Reset: assert `rst` 1 cycle → `q`=0x00, `cmd_ready`=1, `busy`=0, `done`=0.
- LOAD 0xA5:
  - `q`=0xA5 after accept edge.
  - `done` pulses one cycle.
  - `cmd_ready` returns 2 cycles after accept.
  - A second `cmd_valid` held during DONE is not accepted until then.
- ROL count 3 from 0xA5: `q` passes through 0x4B, 0x96, then ends at 0x2D after edge E+3; `done` high in the next cycle.
- ASR count 2 from 0x90 → 0xC8, then 0xE4. SHR count 1 from 0x01 with `ser_in_r`=1 → 0x80.
- SHL count 10 from 0x00 with `ser_in_l`=1: saturates to 8 steps; `q`=0xFF after E+8; `done` during E+8→E+9. ROR count 15 from 0x3C → 0x3C.
- Reset mid-op: SHR count 5 from 0xFF, assert `rst` after 2 steps → next edge `q`=0, IDLE, `cmd_ready`=1, and `done` never pulses.
